// File: rtl/elevator_pkg.sv
// elevator_pkg: scheduler state encoding, travel direction constants and default sizes
// shared by the elevator call scheduler and its floor search helper.
package elevator_pkg;

  localparam int DEF_BUTTONS_WIDTH = 8;
  localparam int DEF_LEVEL_W       = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_floor_search.sv
// elevator_floor_search: combinational scan of a call vector relative to the car floor.
// Reports nearest/farthest calls strictly above and below, plus a hit at the car floor.
module elevator_floor_search #(
  parameter int N  = 8,
  parameter int LW = 3
) (
  input  logic [N-1:0]  calls,
  input  logic [LW-1:0] cur_level,
  output logic          found,
  output logic          above_found,
  output logic          below_found,
  output logic          at_hit,
  output logic [LW-1:0] nearest_above,
  output logic [LW-1:0] highest_above,
  output logic [LW-1:0] nearest_below,
  output logic [LW-1:0] lowest_below
);

  always_comb begin
    found         = |calls;
    above_found   = 1'b0;
    below_found   = 1'b0;
    at_hit        = 1'b0;
    nearest_above = '0;
    highest_above = '0;
    nearest_below = '0;
    lowest_below  = '0;
    // Ascending scan keeps the last hit, i.e. the highest one on each side.
    for (int i = 0; i < N; i++) begin
      if (calls[i] && i > int'(cur_level)) begin
        above_found   = 1'b1;
        highest_above = LW'(i);
      end
      if (calls[i] && i < int'(cur_level)) begin
        below_found   = 1'b1;
        nearest_below = LW'(i);
      end
      if (i == int'(cur_level)) at_hit = calls[i];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (calls[i] && i > int'(cur_level)) nearest_above = LW'(i);
      if (calls[i] && i < int'(cur_level)) lowest_below  = LW'(i);
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: latches cab/hall calls for one car and picks the next target (LOOK).
// Idle parking toward PARK_LEVEL is compiled in only when SCHED_PARK_EN is defined.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH = DEF_BUTTONS_WIDTH,
  parameter int LEVEL_W       = DEF_LEVEL_W,
  parameter int PARK_LEVEL    = 0,
  parameter int PARK_TIMEOUT  = 200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BUTTONS_WIDTH-1:0]   btn_in,
  input  logic [BUTTONS_WIDTH-2:0]   btn_up_out,
  input  logic [BUTTONS_WIDTH-2:0]   btn_down_out,
  input  logic [LEVEL_W-1:0]         cur_level,
  input  logic                       at_floor,
  input  logic                       serve,
  output logic [LEVEL_W-1:0]         target_level,
  output logic                       target_valid,
  output logic                       direction,
  output logic                       stop_req,
  output logic [3*BUTTONS_WIDTH-1:0] call_lamps
);

  localparam int N = BUTTONS_WIDTH;

  logic [N-1:0] cab_reg, up_reg, dn_reg, cab_next, up_next, dn_next;
  logic [N-1:0] floor_hit, up_btn, dn_btn, all_calls, up_calls, dn_calls;
  logic [1:0] state_reg, state_next;
  logic [LEVEL_W-1:0] target_reg, target_next, dist_above, dist_below;
  logic valid_reg, valid_next, dir_reg, dir_next, stop_reg, stop_next;
  logic level_ok, park_hit, go_up, go_dn;

  logic sa_found, sa_above, sa_below, sa_at, su_found, su_above, su_below, su_at;
  logic sd_found, sd_above, sd_below, sd_at, sn_found, sn_above, sn_below, sn_at;
  logic sp_found, sp_above, sp_below, sp_at;
  logic [LEVEL_W-1:0] sa_na, sa_ha, sa_nb, sa_lb, su_na, su_ha, su_nb, su_lb;
  logic [LEVEL_W-1:0] sd_na, sd_ha, sd_nb, sd_lb, sn_na, sn_ha, sn_nb, sn_lb;
  logic [LEVEL_W-1:0] sp_na, sp_ha, sp_nb, sp_lb;

  if (PARK_LEVEL < 0 || PARK_LEVEL >= BUTTONS_WIDTH || PARK_TIMEOUT < 1 ||
      (1 << LEVEL_W) < BUTTONS_WIDTH) begin : g_bad_cfg
    $error("elevator_call_scheduler: inconsistent parameters");
  end

  assign up_btn    = {1'b0, btn_up_out};
  assign dn_btn    = {btn_down_out, 1'b0};
  assign level_ok  = int'(cur_level) < N;
  assign all_calls = cab_reg | up_reg | dn_reg;
  assign up_calls  = cab_reg | up_reg;
  assign dn_calls  = cab_reg | dn_reg;

  for (genvar gi = 0; gi < N; gi++) begin : g_floor
    assign floor_hit[gi] = serve && (int'(cur_level) == gi);
  end

  // Clearing beats a same-cycle press; hall calls are cleared only for the travel direction.
  assign cab_next = (cab_reg | btn_in) & ~floor_hit;
  assign up_next  = (up_reg | up_btn) & ~(floor_hit & {N{state_reg != ST_DOWN}});
  assign dn_next  = (dn_reg | dn_btn) & ~(floor_hit & {N{state_reg != ST_UP}});

  elevator_floor_search #(.N(N), .LW(LEVEL_W)) u_search_all (
    .calls(all_calls), .cur_level(cur_level), .found(sa_found), .above_found(sa_above),
    .below_found(sa_below), .at_hit(sa_at), .nearest_above(sa_na), .highest_above(sa_ha),
    .nearest_below(sa_nb), .lowest_below(sa_lb));
  elevator_floor_search #(.N(N), .LW(LEVEL_W)) u_search_upward (
    .calls(up_calls), .cur_level(cur_level), .found(su_found), .above_found(su_above),
    .below_found(su_below), .at_hit(su_at), .nearest_above(su_na), .highest_above(su_ha),
    .nearest_below(su_nb), .lowest_below(su_lb));
  elevator_floor_search #(.N(N), .LW(LEVEL_W)) u_search_downward (
    .calls(dn_calls), .cur_level(cur_level), .found(sd_found), .above_found(sd_above),
    .below_found(sd_below), .at_hit(sd_at), .nearest_above(sd_na), .highest_above(sd_ha),
    .nearest_below(sd_nb), .lowest_below(sd_lb));
  elevator_floor_search #(.N(N), .LW(LEVEL_W)) u_search_dn_hall (
    .calls(dn_reg), .cur_level(cur_level), .found(sn_found), .above_found(sn_above),
    .below_found(sn_below), .at_hit(sn_at), .nearest_above(sn_na), .highest_above(sn_ha),
    .nearest_below(sn_nb), .lowest_below(sn_lb));
  elevator_floor_search #(.N(N), .LW(LEVEL_W)) u_search_up_hall (
    .calls(up_reg), .cur_level(cur_level), .found(sp_found), .above_found(sp_above),
    .below_found(sp_below), .at_hit(sp_at), .nearest_above(sp_na), .highest_above(sp_ha),
    .nearest_below(sp_nb), .lowest_below(sp_lb));

  // Search results this policy never looks at.
  logic unused_search;
  assign unused_search = ^{sa_found, sa_ha, sa_lb, su_found, su_below, su_ha, su_nb, su_lb,
                           sd_found, sd_above, sd_na, sd_ha, sd_lb, sn_found, sn_above,
                           sn_below, sn_at, sn_na, sn_nb, sn_lb, sp_found, sp_above,
                           sp_below, sp_at, sp_na, sp_ha, sp_nb};

`ifdef SCHED_PARK_EN
  localparam int CNT_W = $clog2(PARK_TIMEOUT + 1);
  logic [CNT_W-1:0] park_cnt_reg, park_cnt_next;
  logic new_press;

  assign new_press = (|btn_in) | (|btn_up_out) | (|btn_down_out);

  always_comb begin
    park_cnt_next = '0;
    if (state_reg == ST_IDLE && !sa_found && !new_press)
      park_cnt_next = (park_cnt_reg == CNT_W'(PARK_TIMEOUT)) ? park_cnt_reg
                                                              : park_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) park_cnt_reg <= '0;
    else       park_cnt_reg <= park_cnt_next;
  end

  assign park_hit = (park_cnt_next == CNT_W'(PARK_TIMEOUT)) &&
                    (cur_level != LEVEL_W'(PARK_LEVEL));
`else
  assign park_hit = 1'b0;
`endif

  assign dist_above = sa_na - cur_level;
  assign dist_below = cur_level - sa_nb;

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    valid_next  = valid_reg;
    dir_next    = dir_reg;
    go_up       = 1'b0;
    go_dn       = 1'b0;
    stop_next   = at_floor && !serve &&
                  ((state_reg == ST_IDLE) ? sa_at : (state_reg == ST_UP) ? su_at : sd_at);
    case (state_reg)
      ST_UP:   if (sa_above) go_up = 1'b1; else if (sa_below) go_dn = 1'b1;
      ST_DOWN: if (sa_below) go_dn = 1'b1; else if (sa_above) go_up = 1'b1;
      default: if (sa_above && (!sa_below || dist_above <= dist_below)) go_up = 1'b1;
               else if (sa_below) go_dn = 1'b1;
    endcase
    if (go_up) begin
      state_next  = ST_UP;
      target_next = su_above ? su_na : sn_ha;
      valid_next  = 1'b1;
      dir_next    = DIR_UP;
    end else if (go_dn) begin
      state_next  = ST_DOWN;
      target_next = sd_below ? sd_nb : sp_lb;
      valid_next  = 1'b1;
      dir_next    = DIR_DOWN;
    end else begin
      state_next = ST_IDLE;
      if (sa_at) begin
        target_next = cur_level;
        valid_next  = 1'b1;
      end else if (park_hit) begin
        target_next = LEVEL_W'(PARK_LEVEL);
        valid_next  = 1'b1;
        dir_next    = (LEVEL_W'(PARK_LEVEL) > cur_level) ? DIR_UP : DIR_DOWN;
      end else begin
        valid_next = 1'b0;
      end
    end
    // An out-of-range floor report freezes the scheduler; calls keep latching.
    if (!level_ok) begin
      state_next  = state_reg;
      target_next = target_reg;
      valid_next  = valid_reg;
      dir_next    = dir_reg;
      stop_next   = stop_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cab_reg    <= '0;
      up_reg     <= '0;
      dn_reg     <= '0;
      state_reg  <= ST_IDLE;
      target_reg <= '0;
      valid_reg  <= 1'b0;
      dir_reg    <= DIR_UP;
      stop_reg   <= 1'b0;
    end else begin
      cab_reg    <= cab_next;
      up_reg     <= up_next;
      dn_reg     <= dn_next;
      state_reg  <= state_next;
      target_reg <= target_next;
      valid_reg  <= valid_next;
      dir_reg    <= dir_next;
      stop_reg   <= stop_next;
    end
  end

  assign target_level = target_reg;
  assign target_valid = valid_reg;
  assign direction    = dir_reg;
  assign stop_req     = stop_reg;
  assign call_lamps   = {dn_reg, up_reg, cab_reg};

endmodule
